// File: rtl/ixu_hazard_ctrl_if.sv
// Decode/writeback/control bundle between the IXU decode stage and the hazard controller.
// master drives decode and writeback info; slave returns stall controls and status.
interface ixu_hazard_ctrl_if #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned CNT_W    = 16
);
  logic                dec_valid;
  logic                dec_is_nop;
  logic                dec_is_imm_type;
  logic [3:0]          dec_op;
  logic [REG_W-1:0]    dec_rs1;
  logic [REG_W-1:0]    dec_rs2;
  logic [REG_W-1:0]    dec_rd;
  logic                wb_valid;
  logic [REG_W-1:0]    wb_rd;
  logic                flush;
  logic                dec_hold;
  logic                idex_bubble;
  logic [NUM_REGS-1:0] busy_vec;
  logic                mul_busy;
  logic [CNT_W-1:0]    stall_cnt;

  modport master (
    output dec_valid, dec_is_nop, dec_is_imm_type, dec_op, dec_rs1, dec_rs2, dec_rd,
    output wb_valid, wb_rd, flush,
    input  dec_hold, idex_bubble, busy_vec, mul_busy, stall_cnt
  );

  modport slave (
    input  dec_valid, dec_is_nop, dec_is_imm_type, dec_op, dec_rs1, dec_rs2, dec_rd,
    input  wb_valid, wb_rd, flush,
    output dec_hold, idex_bubble, busy_vec, mul_busy, stall_cnt
  );
endinterface

// File: rtl/ixu_hazard_ctrl.sv
// Scoreboard hazard controller for the IXU pipe: RAW/WAW/multiplier stalls and a stall counter.
// Optional macro IXU_WB_BYPASS_EN: ignore scoreboard bits being written back this cycle.
module ixu_hazard_ctrl #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned REG_W    = 5,
  parameter logic [3:0]  MUL_OP   = 4'hA,
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned CNT_W    = 16
) (
  input logic               clk,
  input logic               rst_n,
  ixu_hazard_ctrl_if.slave  bus
);

  localparam int unsigned MulW = $clog2(MUL_LAT + 1);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] wb_mask, busy_eff;
  logic [MulW-1:0]     mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic                live, raw, waw, is_mul, mul_busy, hazard, hold, issue;

  always_comb begin
    wb_mask = '0;
    if (bus.wb_valid && bus.wb_rd != '0) begin
      wb_mask[bus.wb_rd] = 1'b1;
    end
  end

`ifdef IXU_WB_BYPASS_EN
  // A register retiring this cycle is forwarded to decode, so it no longer blocks.
  assign busy_eff = busy_q & ~wb_mask & ~NUM_REGS'(1);
`else
  assign busy_eff = busy_q & ~NUM_REGS'(1);
`endif

  assign live     = bus.dec_valid & ~bus.dec_is_nop;
  assign raw      = busy_eff[bus.dec_rs1] | (~bus.dec_is_imm_type & busy_eff[bus.dec_rs2]);
  assign waw      = busy_eff[bus.dec_rd];
  assign is_mul   = (bus.dec_op == MUL_OP);
  assign mul_busy = (mul_cnt_q != '0);
  assign hazard   = live & (raw | waw | (mul_busy & is_mul));
  assign hold     = hazard & ~bus.flush;
  assign issue    = live & ~hazard & ~bus.flush;

  always_comb begin
    // Clear before set so a same-cycle issue to the retiring register stays busy.
    busy_d = busy_q & ~wb_mask;
    if (issue && bus.dec_rd != '0) begin
      busy_d[bus.dec_rd] = 1'b1;
    end

    mul_cnt_d = mul_cnt_q;
    if (issue && is_mul) begin
      mul_cnt_d = MulW'(MUL_LAT);
    end else if (mul_busy) begin
      mul_cnt_d = mul_cnt_q - 1'b1;
    end

    if (bus.flush) begin
      busy_d    = '0;
      mul_cnt_d = '0;
    end

    stall_d = stall_q;
    if (hold && stall_q != '1) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      mul_cnt_q <= '0;
      stall_q   <= '0;
    end else begin
      busy_q    <= busy_d;
      mul_cnt_q <= mul_cnt_d;
      stall_q   <= stall_d;
    end
  end

  assign bus.dec_hold    = hold;
  assign bus.idex_bubble = hold;
  assign bus.busy_vec    = busy_q;
  assign bus.mul_busy    = mul_busy;
  assign bus.stall_cnt   = stall_q;

endmodule

// File: doc/ixu_hazard_ctrl.md
Name: ixu_hazard_ctrl

Overview:
Scoreboard-based hazard controller for the IXU pipe. It sits beside the decode stage and acts as the control end of the ID/EX state register's stall interface. It tracks in-flight destination registers from issue to writeback and checks each decoded instruction for RAW, WAW and multi-cycle-unit structural hazards. It produces the decode hold and the ID/EX bubble-inject controls, plus a saturating stall-cycle counter.

Parameters:
NUM_REGS, 32, architectural integer registers; r0 is never tracked
REG_W, 5, register index width; must equal clog2(NUM_REGS)
MUL_OP, 4'hA, op encoding that occupies the multi-cycle multiplier
MUL_LAT, 3, cycles the multiplier is busy after a MUL issues (≥1)
CNT_W, 16, stall-cycle counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
dec_valid  in  1  decode slot holds an instruction
dec_is_nop  in  1  decoded instruction is a NOP
dec_is_imm_type  in  1  immediate form; rs2 is not read
dec_op  in  4  decoded op
dec_rs1  in  REG_W  source 1
dec_rs2  in  REG_W  source 2
dec_rd  in  REG_W  destination
wb_valid  in  1  writeback retiring a register write this cycle
wb_rd  in  REG_W  register being written back
flush  in  1  squash all in-flight IXU instructions
dec_hold  out  1  hold fetch/decode registers this cycle
idex_bubble  out  1  force is_nop_in=1 into the ID/EX register this cycle
busy_vec  out  NUM_REGS  scoreboard, bit i = register i has a pending write
mul_busy  out  1  multiplier occupied
stall_cnt  out  CNT_W  saturating count of cycles with dec_hold=1

Behaviour:
- Reset (rst_n=0, async): busy_vec=0, mul counter=0, mul_busy=0, stall_cnt=0. dec_hold=0 and idex_bubble=0 while in reset. Reset mid-MUL discards the countdown.
- live = dec_valid & !dec_is_nop.
- raw = busy[rs1] | (!dec_is_imm_type & busy[rs2]). busy[0] always reads 0.
- waw = busy[rd] (rd≠0).
- struct = mul_busy & (dec_op==MUL_OP).
- hazard = live & (raw | waw | struct).
- dec_hold = idex_bubble = hazard & !flush. Both are combinational from current state and decode inputs, with zero-cycle latency.
- issue = live & !hazard & !flush.
- Scoreboard update on the rising edge, applied in order:
  - 1. wb_valid clears busy[wb_rd].
  - 2. issue with rd≠0 sets busy[rd].
  - When set and clear hit the same register in the same cycle, set wins.
  - wb_valid for a non-busy register is ignored. wb_rd=0 is ignored.
- Multiplier counter:
  - issue & dec_op==MUL_OP loads MUL_LAT.
  - Otherwise the counter decrements when nonzero.
  - mul_busy = (counter≠0).
  - A MUL issues only when the counter is 0, so a load never overlaps a countdown.
- flush (synchronous, one cycle): next state busy_vec=0 and counter=0. Same-cycle wb_valid and issue are discarded. dec_hold=0 during flush. stall_cnt is unchanged.
- stall_cnt increments on each edge with dec_hold=1 and saturates at all-ones, with no wrap.
- Without bypass, a source whose writeback lands in the same cycle still stalls. It issues on the next cycle.

Optional Feature:
Macro IXU_WB_BYPASS_EN.
- Defined: the hazard checks use busy_eff = busy & ~(wb_valid ? onehot(wb_rd) : 0). A RAW or WAW hazard on a register being written back this cycle does not stall. Decode reads the forwarded WB value.
- Undefined: the checks use busy_vec directly, which costs one extra stall cycle on that case.
- Structural and flush behaviour are identical in both builds.

Test Plan:
- RAW: issue rd=5 (ADD), next cycle decode rs1=5 with no wb → dec_hold=idex_bubble=1 each cycle. Assert wb_valid, wb_rd=5 → busy_vec[5]=0 next cycle, instruction issues, stall_cnt advances by the exact stalled-cycle count.
- Immediate form: busy[7]=1, decode rs1=3, rs2=7, dec_is_imm_type=1, rd=9 → no hold, busy_vec[9]=1 next cycle. Same decode with imm_type=0 → hold.
- Structural: MUL (op 4'hA, rd=4) issues with MUL_LAT=3. A second MUL (rd=6) follows immediately → held exactly 3 cycles, issues on the 4th. A non-MUL ADD rd=8 is not held during the countdown.
- Same-cycle events:
  - wb_valid wb_rd=10 with issue rd=10 → busy_vec[10]=1.
  - Decode rs1=10 while wb_rd=10: hold=1 without the macro, hold=0 with IXU_WB_BYPASS_EN.
- Flush: busy_vec=0x0000_0130 and counter=2, pulse flush → dec_hold=0 that cycle, busy_vec=0 and mul_busy=0 next cycle. r0 writes never set busy_vec[0].
- Reset mid-operation: deassert rst_n asynchronously mid-MUL with busy bits set → all outputs 0 immediately without a clock edge. Release → pipeline resumes with no hazards. Force dec_hold=1 for 2^CNT_W+5 cycles → stall_cnt saturates at all-ones.
